mem_arbiter: RTL and testbench

- Shares one memory slave port between N bus masters (e.g. cpu core, DMA engine, debug loader).
- All ports use the cpu's valid/ready memory protocol: mem_valid, mem_ready, mem_addr, mem_rdata, mem_wdata, mem_wstrb.
- Sits between the masters and the memory/peripheral interconnect.
- Round-robin arbitration; exactly one transaction is outstanding at the slave at any time.

---
 rtl/mem_arbiter_if.sv | 40 ++++
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module      : mem_arbiter_if
// Description : Valid/ready memory bus bundle between N masters, the arbiter
//               and the shared slave port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
    parameter int N_MASTERS = 2
);
    logic [N_MASTERS-1:0]    m_valid;
    logic [N_MASTERS-1:0]    m_ready;
    logic [32*N_MASTERS-1:0] m_addr;
    logic [32*N_MASTERS-1:0] m_wdata;
    logic [4*N_MASTERS-1:0]  m_wstrb;
    logic [31:0]             m_rdata;
    logic                    s_valid;
    logic                    s_ready;
    logic [31:0]             s_addr;
    logic [31:0]             s_wdata;
    logic [3:0]              s_wstrb;
    logic [31:0]             s_rdata;
    logic [1:0]              grant;
    logic                    busy;

    // Arbiter side
    modport slave (
        input  m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
        output m_ready, m_rdata, s_valid, s_addr, s_wdata, s_wstrb, grant, busy
    );

    // Environment side: requesting masters plus the memory slave
    modport master (
        output m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
        input  m_ready, m_rdata, s_valid, s_addr, s_wdata, s_wstrb, grant, busy
    );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter sharing one valid/ready memory slave port
//               between N_MASTERS masters, one outstanding transaction.
//               Optional slave timeout enabled by macro MEM_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int N_MASTERS      = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mem_arbiter_if.slave       bus
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    output      logic          timeout_err
`endif
);

    if (N_MASTERS < 2 || N_MASTERS > 4) begin : g_bad_n_masters
        $error("mem_arbiter: N_MASTERS must be in 2..4");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYCLES must be in 1..65535");
    end

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t      r_state, w_next;
    logic [1:0]  r_grant, r_last;
    logic [1:0]  w_winner, w_grant_next, w_last_next;
    logic        w_found;
    logic        w_sel_valid;
    logic [31:0] w_addr, w_wdata;
    logic [3:0]  w_wstrb;
    logic        w_timeout;

    // Granted master's request fields; unlatched, masters hold them stable.
    always_comb begin
        w_sel_valid = 1'b0;
        w_addr      = '0;
        w_wdata     = '0;
        w_wstrb     = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (r_grant == 2'(i)) begin
                w_sel_valid = bus.m_valid[i];
                w_addr      = bus.m_addr[32*i +: 32];
                w_wdata     = bus.m_wdata[32*i +: 32];
                w_wstrb     = bus.m_wstrb[4*i +: 4];
            end
        end
    end

    // Search starts one past the last winner and wraps; first requester wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_last;
        for (int k = 1; k <= N_MASTERS; k++) begin
            for (int i = 0; i < N_MASTERS; i++) begin
                if (!w_found && bus.m_valid[i] && (((int'(r_last) + k) % N_MASTERS) == i)) begin
                    w_found  = 1'b1;
                    w_winner = 2'(i);
                end
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    logic [15:0] r_cnt;
    logic        r_timeout_err;

    assign w_timeout   = (r_state == ST_BUSY) && w_sel_valid && !bus.s_ready &&
                         (r_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign timeout_err = r_timeout_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == ST_IDLE)
                r_cnt <= '0;
            else if (!bus.s_ready)
                r_cnt <= r_cnt + 16'd1;
            if (w_timeout)
                r_timeout_err <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_grant <= 2'd0;
            r_last  <= 2'(N_MASTERS - 1);
        end else begin
            r_state <= w_next;
            r_grant <= w_grant_next;
            r_last  <= w_last_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_grant_next = r_grant;
        w_last_next  = r_last;
        bus.s_valid  = 1'b0;
        bus.m_ready  = '0;
        bus.m_rdata  = bus.s_rdata;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_next       = ST_BUSY;
                    w_grant_next = w_winner;
                end
            end
            ST_BUSY: begin
                bus.s_valid = w_sel_valid && !w_timeout;
                if (bus.s_ready || w_timeout) begin
                    for (int i = 0; i < N_MASTERS; i++)
                        if (r_grant == 2'(i))
                            bus.m_ready[i] = 1'b1;
                    if (w_timeout)
                        bus.m_rdata = 32'hDEAD_BEEF;
                    w_last_next = r_grant;
                    w_next      = ST_IDLE;
                end else if (!w_sel_valid) begin
                    // Abandoned request: no completion, fairness pointer untouched.
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign bus.s_addr  = w_addr;
    assign bus.s_wdata = w_wdata;
    assign bus.s_wstrb = w_wstrb;
    assign bus.grant   = r_grant;
    assign bus.busy    = (r_state == ST_BUSY);

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter (two masters).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam int c_N = 2;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    mem_arbiter_if #(.N_MASTERS(c_N)) bus ();

`ifdef MEM_ARB_TIMEOUT_EN
    logic timeout_err;
`endif

    mem_arbiter #(
        .N_MASTERS      (c_N),
        .TIMEOUT_CYCLES (8)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave)
`ifdef MEM_ARB_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b1;
        bus.m_valid = '0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        bus.m_wstrb = '0;
        bus.s_ready = 1'b0;
        bus.s_rdata = '0;

        // Reset state
        do_reset();
        settle();
        check("rst_s_valid", 32'(bus.s_valid), 32'd0);
        check("rst_m_ready", 32'(bus.m_ready), 32'd0);
        check("rst_grant",   32'(bus.grant),   32'd0);
        check("rst_busy",    32'(bus.busy),    32'd0);

        // s_ready while idle is ignored
        bus.s_ready = 1'b1;
        settle();
        check("idle_sready_m_ready", 32'(bus.m_ready), 32'd0);
        tick();
        check("idle_sready_busy", 32'(bus.busy), 32'd0);
        bus.s_ready = 1'b0;

        // Single read by master 0, slave answers in third busy cycle
        bus.m_addr[31:0] = 32'h0000_0100;
        bus.m_wstrb[3:0] = 4'h0;
        bus.m_valid      = 2'b01;
        settle();
        check("rd_idle_s_valid", 32'(bus.s_valid), 32'd0);
        tick();
        check("rd_s_valid", 32'(bus.s_valid), 32'd1);
        check("rd_s_addr",  bus.s_addr,          32'h0000_0100);
        check("rd_s_wstrb", 32'(bus.s_wstrb),    32'd0);
        check("rd_grant",   32'(bus.grant),      32'd0);
        check("rd_wait1_m_ready", 32'(bus.m_ready), 32'd0);
        tick();
        check("rd_wait2_m_ready", 32'(bus.m_ready), 32'd0);
        tick();
        bus.s_ready = 1'b1;
        bus.s_rdata = 32'h1234_5678;
        settle();
        check("rd_m_ready", 32'(bus.m_ready), 32'd1);
        check("rd_m_rdata", bus.m_rdata,      32'h1234_5678);
        tick();
        bus.s_ready = 1'b0;
        bus.m_valid = 2'b00;
        settle();
        check("rd_after_m_ready", 32'(bus.m_ready), 32'd0);
        check("rd_after_busy",    32'(bus.busy),    32'd0);

        // Continuous requests from both masters after reset: 0,1,0,1
        do_reset();
        bus.m_addr  = {32'h0000_2000, 32'h0000_1000};
        bus.m_valid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            logic [1:0] exp_g;
            exp_g = 2'(t % 2);
            settle();
            check("rr_idle_gap", 32'(bus.busy), 32'd0);
            tick();
            check("rr_busy",  32'(bus.busy),  32'd1);
            check("rr_grant", 32'(bus.grant), 32'(exp_g));
            check("rr_s_addr", bus.s_addr, (exp_g == 2'd0) ? 32'h0000_1000 : 32'h0000_2000);
            bus.s_ready = 1'b1;
            bus.s_rdata = 32'h0000_00A0 + 32'(t);
            settle();
            check("rr_m_ready", 32'(bus.m_ready), (exp_g == 2'd0) ? 32'd1 : 32'd2);
            tick();
            bus.s_ready = 1'b0;
        end
        bus.m_valid = 2'b00;

        // Master 1 write while master 0 is idle
        bus.m_addr[63:32]  = 32'h0000_0200;
        bus.m_wdata[63:32] = 32'hA5A5_A5A5;
        bus.m_wstrb[7:4]   = 4'b0100;
        bus.m_valid        = 2'b10;
        tick();
        check("wr_grant",   32'(bus.grant),   32'd1);
        check("wr_s_wdata", bus.s_wdata,      32'hA5A5_A5A5);
        check("wr_s_wstrb", 32'(bus.s_wstrb), 32'h4);
        check("wr_s_addr",  bus.s_addr,       32'h0000_0200);
        bus.s_ready = 1'b1;
        settle();
        check("wr_m_ready", 32'(bus.m_ready), 32'd2);
        tick();
        bus.s_ready = 1'b0;
        bus.m_valid = 2'b00;

        // Master 0 completes, then abandons; contention must favour master 1
        bus.m_valid = 2'b01;
        tick();
        check("ab_pre_grant", 32'(bus.grant), 32'd0);
        bus.s_ready = 1'b1;
        tick();
        bus.s_ready = 1'b0;
        tick();
        check("ab_grant", 32'(bus.grant), 32'd0);
        check("ab_busy",  32'(bus.busy),  32'd1);
        bus.m_valid = 2'b00;
        settle();
        check("ab_s_valid", 32'(bus.s_valid), 32'd0);
        check("ab_m_ready", 32'(bus.m_ready), 32'd0);
        tick();
        check("ab_idle",      32'(bus.busy),    32'd0);
        check("ab_idle_mrdy", 32'(bus.m_ready), 32'd0);
        bus.m_valid = 2'b11;
        tick();
        check("ab_next_grant", 32'(bus.grant), 32'd1);
        bus.s_ready = 1'b1;
        tick();
        bus.s_ready = 1'b0;
        bus.m_valid = 2'b00;

        // Reset while master 1 is being served
        bus.m_valid = 2'b10;
        tick();
        check("rb_grant_pre", 32'(bus.grant), 32'd1);
        rst = 1'b1;
        tick();
        check("rb_s_valid", 32'(bus.s_valid), 32'd0);
        check("rb_m_ready", 32'(bus.m_ready), 32'd0);
        check("rb_grant",   32'(bus.grant),   32'd0);
        check("rb_busy",    32'(bus.busy),    32'd0);
        rst = 1'b0;
        bus.m_valid = 2'b11;
        tick();
        check("rb_first_grant", 32'(bus.grant), 32'd0);
        bus.s_ready = 1'b1;
        tick();
        bus.s_ready = 1'b0;
        bus.m_valid = 2'b00;
        tick();

`ifdef MEM_ARB_TIMEOUT_EN
        // Slave never ready: completion forced in the eighth busy cycle
        do_reset();
        settle();
        check("to_err_rst", 32'(timeout_err), 32'd0);
        bus.m_valid = 2'b01;
        for (int c = 1; c <= 7; c++) begin
            tick();
            check("to_wait_m_ready", 32'(bus.m_ready), 32'd0);
            check("to_wait_err",     32'(timeout_err), 32'd0);
        end
        tick();
        check("to_m_ready", 32'(bus.m_ready), 32'd1);
        check("to_m_rdata", bus.m_rdata,      32'hDEAD_BEEF);
        check("to_s_valid", 32'(bus.s_valid), 32'd0);
        bus.m_valid = 2'b00;
        tick();
        check("to_err_set",  32'(timeout_err), 32'd1);
        check("to_idle",     32'(bus.busy),    32'd0);
        tick();
        tick();
        check("to_err_sticky", 32'(timeout_err), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
